// File: rtl/apb3_pkg.sv
// Shared APB3 definitions: FSM state encoding (matches the slave side) and
// default bus widths.
package apb3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } apb3_state_e;

  localparam int APB3_ADDR_WIDTH = 12;
  localparam int APB3_DATA_WIDTH = 32;

endpackage

// File: rtl/apb3_timeout_counter.sv
// Access-phase wait counter; expired is high once LIMIT-1 waits have been counted.
module apb3_timeout_counter #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT);

  logic [CW-1:0] count_r;

  // Wait-state counter, restarted at the start of every access phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else if (enable) begin
      count_r <= count_r + CW'(1);
    end
  end

  assign expired = (count_r == CW'(LIMIT - 1));

endmodule

// File: rtl/apb3_master_bridge.sv
// APB3 initiator: one valid/ready command becomes one APB3 transfer, answered by a
// one-cycle response strobe. Define APB3_MASTER_TIMEOUT_EN to abort stuck accesses.
module apb3_master_bridge
  import apb3_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB3_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB3_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERROR
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("apb3_master_bridge: TIMEOUT_CYCLES must be >= 2");
  end

  apb3_state_e           state_r;
  apb3_state_e           next_s;
  logic                  accept_s;
  logic                  done_s;
  logic                  abort_s;
  logic                  timeout_s;
  logic [ADDR_WIDTH-1:0] paddr_r;
  logic                  pwrite_r;
  logic [DATA_WIDTH-1:0] pwdata_r;
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_r;
  logic                  rsp_error_r;

`ifdef APB3_MASTER_TIMEOUT_EN
  logic to_clear_s;
  logic to_enable_s;

  assign to_clear_s  = (state_r == ST_SETUP);
  assign to_enable_s = (state_r == ST_ACCESS) && !PREADY;

  apb3_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (to_clear_s),
    .enable  (to_enable_s),
    .expired (timeout_s)
  );
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state decode; PREADY takes priority over a coincident timeout.
  always_comb begin
    next_s   = state_r;
    accept_s = 1'b0;
    done_s   = 1'b0;
    abort_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          next_s   = ST_SETUP;
          accept_s = 1'b1;
        end else begin
          next_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        next_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          next_s = ST_IDLE;
          done_s = 1'b1;
        end else if (timeout_s) begin
          next_s  = ST_IDLE;
          abort_s = 1'b1;
        end else begin
          next_s = ST_ACCESS;
        end
      end
      default: begin
        next_s = ST_IDLE;
      end
    endcase
  end

  // State register, transfer latch (held through the transfer) and response capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      paddr_r     <= {ADDR_WIDTH{1'b0}};
      pwrite_r    <= 1'b0;
      pwdata_r    <= {DATA_WIDTH{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      rsp_error_r <= 1'b0;
    end else begin
      state_r     <= next_s;
      rsp_valid_r <= done_s | abort_s;
      if (accept_s) begin
        paddr_r  <= cmd_addr;
        pwrite_r <= cmd_write;
        pwdata_r <= cmd_wdata;
      end
      if (done_s) begin
        rsp_error_r <= PSLVERROR;
        rsp_rdata_r <= pwrite_r ? {DATA_WIDTH{1'b0}} : PRDATA;
      end else if (abort_s) begin
        rsp_error_r <= 1'b1;
        rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      end
    end
  end

  // Bus strobes come straight from the state register so they cannot glitch.
  assign cmd_ready = (state_r == ST_IDLE);
  assign PSEL      = (state_r == ST_SETUP) || (state_r == ST_ACCESS);
  assign PENABLE   = (state_r == ST_ACCESS);
  assign PADDR     = paddr_r;
  assign PWRITE    = pwrite_r;
  assign PWDATA    = pwdata_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_error = rsp_error_r;

endmodule

// File: tb/tb_apb3_master_bridge.sv
// Self-checking bench for apb3_master_bridge: reactive wait-state slave, a
// timeline model of each transfer, directed cases and randomized traffic.
module tb_apb3_master_bridge;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef APB3_MASTER_TIMEOUT_EN
  localparam int MAXW = 9;
`else
  localparam int MAXW = 4;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          PSLVERROR = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // plan for the command currently offered on cmd_*
  int            p_waits = 0;
  logic          p_err = 1'b0;
  logic [DW-1:0] p_rdata = '0;

  apb3_master_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERROR(PSLVERROR)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endfunction

  // cycles from acceptance to the response strobe
  function automatic int rsp_delay(input int waits);
`ifdef APB3_MASTER_TIMEOUT_EN
    if (waits > TO - 1) return TO + 2;
`endif
    return waits + 3;
  endfunction

  function automatic logic is_abort(input int waits);
`ifdef APB3_MASTER_TIMEOUT_EN
    return (waits > TO - 1);
`else
    return 1'b0;
`endif
  endfunction

  // Slave: latches the plan in SETUP, answers after p_waits access cycles,
  // and drives noise on PREADY/PSLVERROR/PRDATA whenever it is not answering.
  int            s_acc = 0;
  int            s_w = 0;
  logic          s_err = 1'b0;
  logic [DW-1:0] s_rd = '0;
  always @(negedge clk) begin
    if (PSEL && !PENABLE) begin
      s_w = p_waits; s_err = p_err; s_rd = p_rdata; s_acc = 0;
    end
    if (PSEL && PENABLE && (s_acc == s_w)) begin
      PREADY = 1'b1; PSLVERROR = s_err; PRDATA = s_rd;
    end else begin
      PREADY = (PSEL && PENABLE) ? 1'b0 : 1'($urandom);
      PSLVERROR = 1'($urandom); PRDATA = $urandom;
    end
    if (PSEL && PENABLE) s_acc++;
  end

  // Model: transfer timeline measured in cycles since acceptance (m_k).
  int            m_k = 0;
  int            m_rk = 0;
  logic          m_abort = 1'b0;
  logic          m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          m_err = 1'b0;
  logic [DW-1:0] m_rd = '0;
  logic [DW-1:0] e_rdata = '0;
  logic          e_err = 1'b0;
  logic          e_psel, e_pen, e_rv;
  always @(negedge clk) begin
    if (!resetn) begin
      m_k = 0; m_rk = 0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
      e_rdata = '0; e_err = 1'b0;
    end else if (m_k >= 1 && m_k < m_rk) begin
      m_k++;
      if (m_k == m_rk) begin
        e_rdata = (m_abort || m_wr) ? 32'h0 : m_rd;
        e_err   = m_abort | m_err;
      end
    end else if (cmd_valid) begin
      m_k = 1; m_rk = rsp_delay(p_waits); m_abort = is_abort(p_waits);
      m_wr = cmd_write; m_addr = cmd_addr; m_wdata = cmd_wdata;
      m_err = p_err; m_rd = p_rdata;
    end else begin
      m_k = 0;
    end
    e_psel = (m_k >= 1) && (m_k < m_rk);
    e_pen  = (m_k >= 2) && (m_k < m_rk);
    e_rv   = (m_k >= 1) && (m_k == m_rk);
    chk("PSEL", 64'(PSEL), 64'(e_psel));
    chk("PENABLE", 64'(PENABLE), 64'(e_pen));
    chk("cmd_ready", 64'(cmd_ready), 64'(!e_psel));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
    chk("PADDR", 64'(PADDR), 64'(m_addr));
    chk("PWRITE", 64'(PWRITE), 64'(m_wr));
    chk("PWDATA", 64'(PWDATA), 64'(m_wdata));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rdata));
    chk("rsp_error", 64'(rsp_error), 64'(e_err));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Offer a command (caller is idle or in the rsp_valid cycle) and wait for its response.
  task automatic run_txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int waits, input logic err, input logic [DW-1:0] rd,
                         input logic drop, output int lat);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    p_waits = waits; p_err = err; p_rdata = rd;
    step();
    lat = 1;
    if (drop) begin
      cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 12'($urandom); cmd_wdata = $urandom;
    end
    while (!rsp_valid && lat < 64) begin
      step();
      lat++;
    end
    chk("latency", 64'(lat), 64'(rsp_delay(waits)));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, gap, wt;
    step(); step();
    resetn = 1'b1;
    step();
    chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("reset_psel", 64'(PSEL), 64'd0);

    // write 0x1 to 0x004, zero wait states
    run_txn(1'b1, 12'h004, 32'h0000_0001, 0, 1'b0, 32'hFFFF_FFFF, 1'b1, lat);
    chk("wr_lat", 64'(lat), 64'd3);
    chk("wr_rdata", 64'(rsp_rdata), 64'h0);
    chk("wr_err", 64'(rsp_error), 64'd0);
    step();

    // read 0x014, two wait states
    run_txn(1'b0, 12'h014, 32'h0, 2, 1'b0, 32'hABCD_5678, 1'b1, lat);
    chk("rd_lat", 64'(lat), 64'd5);
    chk("rd_rdata", 64'(rsp_rdata), 64'hABCD_5678);
    step(); step();

    // back-to-back with cmd_valid held high
    run_txn(1'b1, 12'h000, 32'hCAFE_0000, 0, 1'b0, 32'h0, 1'b0, lat);
    run_txn(1'b0, 12'h034, 32'h0, 0, 1'b0, 32'h1234_0034, 1'b1, lat2);
    chk("b2b_lat", 64'(lat + lat2), 64'd6);
    chk("b2b_rdata", 64'(rsp_rdata), 64'h1234_0034);
    step();

    // slave error on a read, then a clean write clears it
    run_txn(1'b0, 12'h040, 32'h0, 1, 1'b1, 32'hDEAD_BEEF, 1'b1, lat);
    chk("err_flag", 64'(rsp_error), 64'd1);
    chk("err_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
    run_txn(1'b1, 12'h044, 32'h0000_00A5, 0, 1'b0, 32'h0, 1'b1, lat);
    chk("clean_err", 64'(rsp_error), 64'd0);
    step();

    // reset asserted during ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h0F0; cmd_wdata = 32'h5555_AAAA;
    p_waits = 5; p_err = 1'b0; p_rdata = 32'h0;
    step();
    cmd_valid = 1'b0;
    step(); step();
    resetn = 1'b0;
    #1;
    chk("rst_psel", 64'(PSEL), 64'd0);
    chk("rst_penable", 64'(PENABLE), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    step(); step();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_ready", 64'(cmd_ready), 64'd1);
      chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
    end

`ifdef APB3_MASTER_TIMEOUT_EN
    // PREADY never comes: abort after TO access cycles
    run_txn(1'b0, 12'h100, 32'h0, 1000, 1'b0, 32'h7777_7777, 1'b1, lat);
    chk("to_lat", 64'(lat), 64'd10);
    chk("to_err", 64'(rsp_error), 64'd1);
    chk("to_rdata", 64'(rsp_rdata), 64'h0);
    step();
    // PREADY on the last allowed cycle wins
    run_txn(1'b0, 12'h104, 32'h0, 7, 1'b0, 32'h0BAD_F00D, 1'b1, lat);
    chk("to_edge_lat", 64'(lat), 64'd10);
    chk("to_edge_err", 64'(rsp_error), 64'd0);
    chk("to_edge_rdata", 64'(rsp_rdata), 64'h0BAD_F00D);
    step();
`endif

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      wt = $urandom_range(0, MAXW);
      run_txn(1'($urandom), 12'($urandom), $urandom, wt, 1'($urandom), $urandom,
              1'($urandom_range(0, 3) != 0), lat);
      cmd_valid = 1'b0;
      gap = $urandom_range(0, 2);
      repeat (gap) step();
    end
    cmd_valid = 1'b0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
